adc_channel_averager: RTL

- Sits directly downstream of the modular ADC response stream in the sys_clk domain.
- Accumulates 2^AVG_LOG2 consecutive samples independently for each ADC channel.
- When a channel's block completes, emits one averaged 12-bit code plus its millivolt value (Vref 2500 mV, 12-bit scale) on a ready/valid output port.
- Replaces the raw per-sample latch feeding LEDs and readout logic.

---
 rtl/adc_channel_averager_if.sv | 22 ++
 rtl/adc_channel_averager.sv | 127 ++++++++++++
 2 files changed

// File: rtl/adc_channel_averager_if.sv
// ADC response stream and averaged-result handshake, bundled between the
// averager and its producer/consumer.
interface adc_channel_averager_if;
  logic        response_valid;
  logic [4:0]  response_channel;
  logic [11:0] response_data;
  logic        avg_valid;
  logic        avg_ready;
  logic [4:0]  avg_channel;
  logic [11:0] avg_data;
  logic [11:0] avg_mv;

  modport master (
    output response_valid, response_channel, response_data, avg_ready,
    input  avg_valid, avg_channel, avg_data, avg_mv
  );

  modport slave (
    input  response_valid, response_channel, response_data, avg_ready,
    output avg_valid, avg_channel, avg_data, avg_mv
  );
endinterface

// File: rtl/adc_channel_averager.sv
// Per-channel block averager for the ADC response stream.
// Stage 1 captures a finished block average; stage 2 is the ready/valid output
// register, which also converts the code to millivolts. Stage 1 never stalls:
// a result arriving while the output is held is dropped and flagged sticky.
module adc_channel_averager #(
  parameter int AVG_LOG2 = 3,
  parameter int NUM_CH   = 9
) (
  input  logic                   sys_clk,
  input  logic                   reset,
  input  logic                   clear,
  adc_channel_averager_if.slave  bus,
  output logic                   overflow
);
  localparam int            CW       = (AVG_LOG2 == 0) ? 1 : AVG_LOG2;
  localparam int            AW       = 12 + AVG_LOG2;
  // With AVG_LOG2=0 this is 0 and cnt never leaves 0, so every sample completes.
  localparam logic [CW-1:0] CNT_LAST = CW'((1 << AVG_LOG2) - 1);

  logic [AW-1:0] acc_q [NUM_CH];
  logic [AW-1:0] acc_d [NUM_CH];
  logic [CW-1:0] cnt_q [NUM_CH];
  logic [CW-1:0] cnt_d [NUM_CH];

  logic          s1_valid_q, s1_valid_d;
  logic [4:0]    s1_ch_q, s1_ch_d;
  logic [11:0]   s1_avg_q, s1_avg_d;

  logic          avg_valid_q, avg_valid_d;
  logic [4:0]    avg_channel_q, avg_channel_d;
  logic [11:0]   avg_data_q, avg_data_d;
  logic [11:0]   avg_mv_q, avg_mv_d;
  logic          overflow_q, overflow_d;

  logic          accept;
  logic [23:0]   mv_prod;

  assign accept = bus.response_valid && !clear && (bus.response_channel < 5'(NUM_CH));

  // Accumulate accepted samples per channel; hand a finished block to stage 1.
  always_comb begin
    acc_d      = acc_q;
    cnt_d      = cnt_q;
    s1_valid_d = 1'b0;
    s1_ch_d    = s1_ch_q;
    s1_avg_d   = s1_avg_q;
    for (int i = 0; i < NUM_CH; i++) begin
      if (clear) begin
        acc_d[i] = '0;
        cnt_d[i] = '0;
      end else if (accept && (bus.response_channel == 5'(i))) begin
        if (cnt_q[i] == CNT_LAST) begin
          s1_valid_d = 1'b1;
          s1_ch_d    = 5'(i);
          s1_avg_d   = 12'((acc_q[i] + AW'(bus.response_data)) >> AVG_LOG2);
          acc_d[i]   = '0;
          cnt_d[i]   = '0;
        end else begin
          acc_d[i] = acc_q[i] + AW'(bus.response_data);
          cnt_d[i] = cnt_q[i] + CW'(1);
        end
      end
    end
  end

  // Output register: load a stage-1 result when the slot is free, else drop it.
  always_comb begin
    avg_valid_d   = avg_valid_q;
    avg_channel_d = avg_channel_q;
    avg_data_d    = avg_data_q;
    avg_mv_d      = avg_mv_q;
    overflow_d    = overflow_q;
    mv_prod       = 24'(s1_avg_q) * 24'd2500;
    if (clear) begin
      overflow_d = 1'b0;
    end
    if (s1_valid_q && !clear) begin
      if (!avg_valid_q || bus.avg_ready) begin
        avg_valid_d   = 1'b1;
        avg_channel_d = s1_ch_q;
        avg_data_d    = s1_avg_q;
        avg_mv_d      = mv_prod[23:12];
      end else begin
        overflow_d = 1'b1;
      end
    end else if (avg_valid_q && bus.avg_ready) begin
      avg_valid_d = 1'b0;
    end
  end

  // State registers, all cleared by the asynchronous reset.
  always_ff @(posedge sys_clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_CH; i++) begin
        acc_q[i] <= '0;
        cnt_q[i] <= '0;
      end
      s1_valid_q    <= 1'b0;
      s1_ch_q       <= '0;
      s1_avg_q      <= '0;
      avg_valid_q   <= 1'b0;
      avg_channel_q <= '0;
      avg_data_q    <= '0;
      avg_mv_q      <= '0;
      overflow_q    <= 1'b0;
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        acc_q[i] <= acc_d[i];
        cnt_q[i] <= cnt_d[i];
      end
      s1_valid_q    <= s1_valid_d;
      s1_ch_q       <= s1_ch_d;
      s1_avg_q      <= s1_avg_d;
      avg_valid_q   <= avg_valid_d;
      avg_channel_q <= avg_channel_d;
      avg_data_q    <= avg_data_d;
      avg_mv_q      <= avg_mv_d;
      overflow_q    <= overflow_d;
    end
  end

  assign bus.avg_valid   = avg_valid_q;
  assign bus.avg_channel = avg_channel_q;
  assign bus.avg_data    = avg_data_q;
  assign bus.avg_mv      = avg_mv_q;
  assign overflow        = overflow_q;
endmodule
